// File: rtl/graphic_unit_scheduler_pkg.sv
// Shared types for the graphic unit scheduler: FSM states, schedule-entry layout
// and the cfg_wdata field map.
package graphic_unit_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_WAIT,
    S_NEXT_LINE,
    S_DONE
  } state_t;

  localparam int MAX_UNITS  = 16;
  localparam int ID_W       = 4;
  localparam int Y_W        = 12;
  localparam int CFG_EN_BIT = 31;
  localparam int CFG_ID_LSB = 24;
  localparam int CFG_YS_LSB = 12;
  localparam int CFG_YE_LSB = 0;

  typedef struct packed {
    logic            en;
    logic [ID_W-1:0] id;
    logic [Y_W-1:0]  y_start;
    logic [Y_W-1:0]  y_end;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // cfg_wdata[30:28] are reserved and not stored.
  function automatic entry_t cfg_to_entry(input logic en, input logic [27:0] w);
    entry_t e;
    e.en      = en;
    e.id      = w[CFG_ID_LSB +: ID_W];
    e.y_start = w[CFG_YS_LSB +: Y_W];
    e.y_end   = w[CFG_YE_LSB +: Y_W];
    return e;
  endfunction

endpackage

// File: rtl/graphic_unit_scheduler_if.sv
// Scheduler <-> graphic unit array bundle: shared dy, start pulses and the
// per-unit done/dx/wr/data return path.
interface graphic_unit_scheduler_if #(
  parameter int N_UNITS = 4
);
  logic [11:0]           dy;
  logic [N_UNITS-1:0]    start;
  logic [N_UNITS-1:0]    unit_done;
  logic [12*N_UNITS-1:0] unit_dx;
  logic [N_UNITS-1:0]    unit_wr;
  logic [N_UNITS-1:0]    unit_data;

  modport master (
    output dy, start,
    input  unit_done, unit_dx, unit_wr, unit_data
  );

  modport slave (
    input  dy, start,
    output unit_done, unit_dx, unit_wr, unit_data
  );
endinterface

// File: rtl/graphic_unit_scheduler_table.sv
// Schedule table: N_ENTRIES register file, cleared by reset, writable only while
// the scheduler is idle, read combinationally by the walking index.
module graphic_unit_scheduler_table
  import graphic_unit_scheduler_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             busy,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  entry_t           wdata,
  input  logic [IDX_W-1:0] raddr,
  output entry_t           rdata
);

  entry_t mem_reg [N_ENTRIES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ENTRIES; i++) mem_reg[i] <= '0;
    end else if (we && !busy) begin
      mem_reg[waddr] <= wdata;
    end
  end

  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/graphic_unit_scheduler.sv
// Frame sequencer for the graphic unit array: walks scanlines and schedule entries,
// starts matching units one at a time and forwards their pixel writes.
module graphic_unit_scheduler
  import graphic_unit_scheduler_pkg::*;
#(
  parameter int N_UNITS   = 4,
  parameter int N_ENTRIES = 8,
  parameter int LINES     = 240,
  parameter int TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         frame_start,
  input  logic                         cfg_we,
  input  logic [$clog2(N_ENTRIES)-1:0] cfg_addr,
  input  logic [31:0]                  cfg_wdata,
  graphic_unit_scheduler_if.master     units,
  output logic                         fb_wr,
  output logic [11:0]                  fb_x,
  output logic [11:0]                  fb_y,
  output logic                         fb_data,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         timeout_err
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [11:0]        dy_reg;
  logic [ID_W-1:0]    cur_id_reg;
  logic [TMR_W-1:0]   timer_reg;
  logic [N_UNITS-1:0] start_reg;
  logic               busy_reg, frame_done_reg, timeout_err_reg;
  logic               fb_wr_reg, fb_data_reg;
  logic [11:0]        fb_x_reg, fb_y_reg;

  entry_t rd_entry;
  logic   entry_hit, idx_last;

  // Unit return signals padded to 16 so the 4-bit id indexes them directly.
  logic [MAX_UNITS-1:0] done_pad, wr_pad, data_pad;
  logic [11:0]          dx_pad [MAX_UNITS];
  logic [N_UNITS-1:0]   id_sel;

  generate
    for (genvar gi = 0; gi < MAX_UNITS; gi++) begin : g_pad
      if (gi < N_UNITS) begin : g_live
        assign done_pad[gi] = units.unit_done[gi];
        assign wr_pad[gi]   = units.unit_wr[gi];
        assign data_pad[gi] = units.unit_data[gi];
        assign dx_pad[gi]   = units.unit_dx[12*gi +: 12];
        assign id_sel[gi]   = (cur_id_reg == ID_W'(gi));
      end else begin : g_tie
        assign done_pad[gi] = 1'b0;
        assign wr_pad[gi]   = 1'b0;
        assign data_pad[gi] = 1'b0;
        assign dx_pad[gi]   = '0;
      end
    end
  endgenerate

  graphic_unit_scheduler_table #(
    .N_ENTRIES(N_ENTRIES),
    .IDX_W    (IDX_W)
  ) u_table (
    .clk    (clk),
    .reset_n(reset_n),
    .busy   (busy_reg),
    .we     (cfg_we),
    .waddr  (cfg_addr),
    .wdata  (cfg_to_entry(cfg_wdata[CFG_EN_BIT], cfg_wdata[27:0])),
    .raddr  (idx_reg),
    .rdata  (rd_entry)
  );

  assign entry_hit = rd_entry.en
                   && ({1'b0, rd_entry.id} < 5'(N_UNITS))
                   && (rd_entry.y_start <= dy_reg)
                   && (dy_reg <= rd_entry.y_end);
  assign idx_last  = (idx_reg == IDX_W'(N_ENTRIES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      dy_reg          <= '0;
      cur_id_reg      <= '0;
      timer_reg       <= '0;
      start_reg       <= '0;
      busy_reg        <= 1'b0;
      frame_done_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      fb_wr_reg       <= 1'b0;
      fb_data_reg     <= 1'b0;
      fb_x_reg        <= '0;
      fb_y_reg        <= '0;
    end else begin
      start_reg      <= '0;
      frame_done_reg <= 1'b0;
      fb_wr_reg      <= (state_reg == S_WAIT) && wr_pad[cur_id_reg];
      fb_x_reg       <= dx_pad[cur_id_reg];
      fb_y_reg       <= dy_reg;
      fb_data_reg    <= data_pad[cur_id_reg];
      case (state_reg)
        S_IDLE: if (frame_start) begin
          dy_reg    <= '0;
          idx_reg   <= '0;
          busy_reg  <= 1'b1;
          state_reg <= S_FETCH;
        end
        S_FETCH: begin
          if (entry_hit) begin
            cur_id_reg <= rd_entry.id;
            state_reg  <= S_START;
          end else if (idx_last) begin
            state_reg <= S_NEXT_LINE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        S_START: begin
          start_reg <= id_sel;
          timer_reg <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle takes priority and raises no error.
          if (done_pad[cur_id_reg] || timer_reg == TMR_W'(TIMEOUT)) begin
            if (!done_pad[cur_id_reg]) timeout_err_reg <= 1'b1;
            if (idx_last) begin
              state_reg <= S_NEXT_LINE;
            end else begin
              idx_reg   <= idx_reg + 1'b1;
              state_reg <= S_FETCH;
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        S_NEXT_LINE: begin
          if (dy_reg == 12'(LINES - 1)) begin
            state_reg <= S_DONE;
          end else begin
            dy_reg    <= dy_reg + 12'd1;
            idx_reg   <= '0;
            state_reg <= S_FETCH;
          end
        end
        S_DONE: begin
          frame_done_reg <= 1'b1;
          busy_reg       <= 1'b0;
          state_reg      <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign units.dy    = dy_reg;
  assign units.start = start_reg;
  assign fb_wr       = fb_wr_reg;
  assign fb_x        = fb_x_reg;
  assign fb_y        = fb_y_reg;
  assign fb_data     = fb_data_reg;
  assign busy        = busy_reg;
  assign frame_done  = frame_done_reg;
  assign timeout_err = timeout_err_reg;

endmodule
